// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event classifier: FSM state encoding and ms->clock-tick conversion.
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } key_state_e;

    // freq_mhz clock cycles elapse per microsecond, so 1000*freq_mhz per millisecond
    function automatic int unsigned ms_to_ticks(input int unsigned ms, input int unsigned freq_mhz);
        return ms * 32'd1000 * freq_mhz;
    endfunction

endpackage

// File: rtl/key_evt_timer.sv
// Saturating state timer: cleared on request, counts while enabled, flags equality with a limit.
module key_evt_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             match_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_c = (cnt == limit);

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key gestures into single click, double click and long press events.
// Optional auto-repeat while long-held is enabled by defining KEY_REPEAT_EN.
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 100,
    parameter int unsigned CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_level,
    input  logic       key_press,
    input  logic       key_release,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic       long_release,
    output logic       key_repeat,
    output logic       busy,
    output logic [7:0] click_cnt
);

    localparam int unsigned LONG_T = ms_to_ticks(LONG_MS, FREQ);
    localparam int unsigned DCLK_T = ms_to_ticks(DCLICK_MS, FREQ);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_T - 1);
    localparam logic [CNT_W-1:0] DCLK_LIM = CNT_W'(DCLK_T - 1);
`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_T = ms_to_ticks(REPEAT_MS, FREQ);
    localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REP_T - 1);
`else
    localparam int unsigned unused_repeat_ms = REPEAT_MS;
`endif

    key_state_e       state, state_nxt;
    logic             press_v, rel_v;
    logic             match_c, restart, timer_clr;
    logic [CNT_W-1:0] limit;
    logic             sc_nxt, dc_nxt, lp_nxt, lr_nxt, rep_nxt;

    // Gestures are tracked purely from the edge pulses; the level is not needed
    logic unused_key_level;
    assign unused_key_level = key_level;

    // Simultaneous press and release pulses are contradictory and dropped
    assign press_v = key_press & ~key_release;
    assign rel_v   = key_release & ~key_press;

    always_comb begin
        state_nxt = state;
        sc_nxt    = 1'b0;
        dc_nxt    = 1'b0;
        lp_nxt    = 1'b0;
        lr_nxt    = 1'b0;
        rep_nxt   = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (press_v) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (rel_v) begin
                    state_nxt = WAIT2;
                end else if (match_c) begin
                    state_nxt = LONG;
                    lp_nxt    = 1'b1;
                end
            end
            WAIT2: begin
                if (press_v) begin
                    state_nxt = PRESS2;
                end else if (match_c) begin
                    state_nxt = IDLE;
                    sc_nxt    = 1'b1;
                end
            end
            PRESS2: begin
                if (rel_v) begin
                    state_nxt = IDLE;
                    dc_nxt    = 1'b1;
                end else if (match_c) begin
                    state_nxt = LONG;
                    lp_nxt    = 1'b1;
                end
            end
            LONG: begin
                if (rel_v) begin
                    state_nxt = IDLE;
                    lr_nxt    = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                else if (match_c) begin
                    rep_nxt = 1'b1;
                    restart = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Compare value depends on which deadline the current state is waiting for
    always_comb begin
        limit = LONG_LIM;
        case (state)
            WAIT2:   limit = DCLK_LIM;
`ifdef KEY_REPEAT_EN
            LONG:    limit = REP_LIM;
`endif
            default: limit = LONG_LIM;
        endcase
    end

    assign timer_clr = (state_nxt != state) | restart;

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (state != IDLE),
        .limit   (limit),
        .match_c (match_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            long_release <= 1'b0;
            key_repeat   <= 1'b0;
            busy         <= 1'b0;
            click_cnt    <= 8'd0;
        end else begin
            state        <= state_nxt;
            single_click <= sc_nxt;
            double_click <= dc_nxt;
            long_press   <= lp_nxt;
            long_release <= lr_nxt;
            key_repeat   <= rep_nxt;
            busy         <= (state_nxt != IDLE);
            if (sc_nxt || dc_nxt) click_cnt <= click_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier with short timing (LONG_T=2000, DCLK_T=1000, REP_T=1000).
module tb_key_event_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_level, key_press, key_release;
    logic       single_click, double_click, long_press, long_release, key_repeat, busy;
    logic [7:0] click_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_clicks;

    int first_sc, first_dc, first_lp, first_lr, first_rep;
    int n_sc, n_dc, n_lp, n_lr, n_rep, n_multi, n_busy;

    key_event_classifier #(
        .FREQ      (1),
        .LONG_MS   (2),
        .DCLICK_MS (1),
        .REPEAT_MS (1),
        .CNT_W     (26)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_release  (key_release),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .long_release (long_release),
        .key_repeat   (key_repeat),
        .busy         (busy),
        .click_cnt    (click_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge
    task automatic step(input logic p, input logic r, input logic lvl);
        key_press   = p;
        key_release = r;
        key_level   = lvl;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        first_sc = -1; first_dc = -1; first_lp = -1; first_lr = -1; first_rep = -1;
        n_sc = 0; n_dc = 0; n_lp = 0; n_lr = 0; n_rep = 0; n_multi = 0; n_busy = 0;
    endtask

    task automatic record(input int t);
        int hi;
        hi = int'(single_click) + int'(double_click) + int'(long_press)
           + int'(long_release) + int'(key_repeat);
        if (hi > 1) n_multi++;
        if (busy) n_busy++;
        if (single_click) begin n_sc++;  if (first_sc  < 0) first_sc  = t; end
        if (double_click) begin n_dc++;  if (first_dc  < 0) first_dc  = t; end
        if (long_press)   begin n_lp++;  if (first_lp  < 0) first_lp  = t; end
        if (long_release) begin n_lr++;  if (first_lr  < 0) first_lr  = t; end
        if (key_repeat)   begin n_rep++; if (first_rep < 0) first_rep = t; end
    endtask

    // Press/release pulses at given cycles (-1 = none); cycle 0 is the first press
    task automatic run(input int pa, input int ra, input int pb, input int rb, input int len);
        logic lvl, p, r;
        lvl = 1'b1;
        clear_stats();
        for (int t = 0; t < len; t++) begin
            p = (t == pa) || (t == pb);
            r = (t == ra) || (t == rb);
            if (p && !r) lvl = 1'b0;
            if (r && !p) lvl = 1'b1;
            step(p, r, lvl);
            record(t + 1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        key_level   = 1'b1;
        key_press   = 1'b0;
        key_release = 1'b0;
        exp_clicks  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_clicks", int'(click_cnt), 0);
        chk("rst_pulses", int'({single_click, double_click, long_press, long_release, key_repeat}), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        // single click
        run(0, 100, -1, -1, 1300);
        exp_clicks++;
        chk("single_at", first_sc, 1101);
        chk("single_n", n_sc, 1);
        chk("single_no_dbl", n_dc, 0);
        chk("single_cnt", int'(click_cnt), exp_clicks);
        chk("single_idle", int'(busy), 0);
        chk("single_excl", n_multi, 0);

        // double click
        run(0, 100, 500, 600, 1800);
        exp_clicks++;
        chk("dbl_at", first_dc, 601);
        chk("dbl_n", n_dc, 1);
        chk("dbl_no_single", n_sc, 0);
        chk("dbl_cnt", int'(click_cnt), exp_clicks);
        chk("dbl_excl", n_multi, 0);

        // long press held to 5000
        run(0, 5000, -1, -1, 5100);
        chk("long_at", first_lp, 2001);
        chk("long_n", n_lp, 1);
        chk("long_rel_at", first_lr, 5001);
        chk("long_rel_n", n_lr, 1);
`ifdef KEY_REPEAT_EN
        chk("rep_first", first_rep, 3001);
        chk("rep_n", n_rep, 2);
`else
        chk("rep_n", n_rep, 0);
`endif
        chk("long_no_click", n_sc + n_dc, 0);
        chk("long_cnt", int'(click_cnt), exp_clicks);
        chk("long_excl", n_multi, 0);

        // second press held becomes long press, first click discarded
        run(0, 100, 500, 3000, 3100);
        chk("p2long_at", first_lp, 2501);
        chk("p2long_no_dbl", n_dc, 0);
        chk("p2long_no_sc", n_sc, 0);
        chk("p2long_rel_at", first_lr, 3001);
        chk("p2long_rep", n_rep, 0);
        chk("p2long_cnt", int'(click_cnt), exp_clicks);

        // simultaneous press+release in IDLE is ignored
        run(0, 0, -1, -1, 20);
        chk("both_busy", n_busy, 0);
        chk("both_events", n_sc + n_dc + n_lp + n_lr + n_rep, 0);

        // reset mid-press with the key still held, then a stray release
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        chk("mid_busy_before", int'(busy), 1);
        for (int t = 1; t < 50; t++) step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        for (int t = 50; t < 60; t++) step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int t = 60; t < 230; t++) begin
            step(1'b0, (t == 200), (t < 200) ? 1'b0 : 1'b1);
            record(t + 1);
        end
        exp_clicks = 0;
        chk("mid_busy", n_busy, 0);
        chk("mid_events", n_sc + n_dc + n_lp + n_lr + n_rep, 0);
        chk("mid_cnt", int'(click_cnt), 0);

        // counter wrap using fast double clicks (each adds one, like a single)
        for (int i = 0; i < 255; i++) run(0, 1, 2, 3, 6);
        chk("wrap_255", int'(click_cnt), 255);
        run(0, 1, 2, 3, 6);
        chk("wrap_dbl_at", first_dc, 4);
        chk("wrap_0", int'(click_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
